// File: rtl/wb_port_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// wb_port_arbiter_pkg
//   Shared definitions for the register-file write-port arbiter:
//   architectural register constants, default exception remap values, and the
//   FIFO entry layout used for parked mult/div results.
// -----------------------------------------------------------------------------
package wb_port_arbiter_pkg;

    localparam logic [4:0]  REG_ZERO     = 5'd0;
    localparam logic [4:0]  REG_RA       = 5'd31;
    localparam logic [4:0]  DEF_EXC_REG  = 5'd30;
    localparam logic [31:0] DEF_EXC_CODE = 32'd4;

    // One parked mult/div result. valid=0 marks a squashed (or r0) result that
    // still occupies its slot until it is popped.
    typedef struct packed {
        logic        valid;
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_entry_t;

    // True when an entry is a live pending write to a real register r.
    function automatic logic entry_hits(input wb_entry_t e, input logic [4:0] r);
        return e.valid && (e.rd == r) && (r != REG_ZERO);
    endfunction

endpackage

// File: rtl/wb_result_fifo.sv
// -----------------------------------------------------------------------------
// wb_result_fifo
//   Circular buffer of parked mult/div results with per-entry squash by
//   destination register and two combinational match-query ports.
//
//   Ports:
//     clock, reset                 clock / async active-high reset
//     i_push, i_push_valid/reg/data  write one entry at the tail
//     i_pop                        drop the head entry
//     i_squash_en, i_squash_reg    clear valid of every entry writing that reg
//     i_query_a_reg, i_query_b_reg hazard query registers
//     o_query_a_hit, o_query_b_hit live entry exists for the queried register
//     o_head_valid/reg/data        current head entry
//     o_count, o_empty, o_full     occupancy (invalid entries included)
// -----------------------------------------------------------------------------
module wb_result_fifo
    import wb_port_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     i_push,
    input  logic                     i_push_valid,
    input  logic [4:0]               i_push_reg,
    input  logic [31:0]              i_push_data,
    input  logic                     i_pop,
    input  logic                     i_squash_en,
    input  logic [4:0]               i_squash_reg,
    input  logic [4:0]               i_query_a_reg,
    input  logic [4:0]               i_query_b_reg,
    output logic                     o_query_a_hit,
    output logic                     o_query_b_hit,
    output logic                     o_head_valid,
    output logic [4:0]               o_head_reg,
    output logic [31:0]              o_head_data,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_empty,
    output logic                     o_full
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    wb_entry_t         r_mem [DEPTH];
    logic [PW-1:0]     r_wr_ptr;
    logic [PW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_count;

    logic              w_do_push;
    logic              w_do_pop;
    wb_entry_t         w_push_entry;
    logic              w_hit_a;
    logic              w_hit_b;

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == CW'(DEPTH));
    assign o_count = r_count;

    // Guards keep the pointers coherent even if a caller misbehaves; a push
    // into a full buffer is only allowed when the head leaves the same cycle.
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    assign w_push_entry = '{valid: i_push_valid, rd: i_push_reg, data: i_push_data};

    assign o_head_valid = r_mem[r_rd_ptr].valid;
    assign o_head_reg   = r_mem[r_rd_ptr].rd;
    assign o_head_data  = r_mem[r_rd_ptr].data;

    // Popped slots have their valid bit cleared, so a set valid bit always
    // means "occupied and live" and the queries need no occupancy mask.
    always_comb begin
        w_hit_a = 1'b0;
        w_hit_b = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (entry_hits(r_mem[i], i_query_a_reg)) w_hit_a = 1'b1;
            if (entry_hits(r_mem[i], i_query_b_reg)) w_hit_b = 1'b1;
        end
    end

    assign o_query_a_hit = w_hit_a;
    assign o_query_b_hit = w_hit_b;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (i_squash_en && (r_mem[i].rd == i_squash_reg)) begin
                    r_mem[i].valid <= 1'b0;
                end
            end
            if (w_do_pop) begin
                r_mem[r_rd_ptr].valid <= 1'b0;
                r_rd_ptr              <= r_rd_ptr + 1'b1;
            end
            // Placed after the pop so a full-buffer push into the slot being
            // vacated wins over the pop's valid clear.
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= w_push_entry;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_do_push && w_do_pop) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// -----------------------------------------------------------------------------
// wb_port_arbiter
//   Shares the register-file write port between the pipeline writeback stage
//   (always wins) and the mult/div unit, whose results park in a small FIFO
//   and drain into idle writeback slots. Also answers decode hazard queries
//   against pending mult/div writes and squashes stale mult/div results when
//   a younger pipeline instruction writes the same register.
//
//   Ports:
//     clock, reset            clock / async active-high reset
//     wb_wren/reg/data        pipeline writeback request
//     md_valid/reg/data       mult/div result offer
//     md_exception            result is an exception (remapped to EXC_REG)
//     md_stall                FIFO full; mult/div holds its result
//     rf_wren/reg/data        registered register-file write
//     query_a/b_reg, _hit     hazard queries against pending FIFO entries
//     pending_count           occupied FIFO slots
//
//   Handshake: a mult/div result transfers on any cycle with md_valid=1 and
//   md_stall=0. While md_stall=1 nothing transfers and the mult/div unit must
//   keep md_valid/md_reg/md_data/md_exception stable. md_stall depends only
//   on registered occupancy, never on this cycle's inputs.
// -----------------------------------------------------------------------------
module wb_port_arbiter
    import wb_port_arbiter_pkg::*;
#(
    parameter int          DEPTH    = 2,
    parameter logic [4:0]  EXC_REG  = DEF_EXC_REG,
    parameter logic [31:0] EXC_CODE = DEF_EXC_CODE
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     wb_wren,
    input  logic [4:0]               wb_reg,
    input  logic [31:0]              wb_data,
    input  logic                     md_valid,
    input  logic [4:0]               md_reg,
    input  logic [31:0]              md_data,
    input  logic                     md_exception,
    output logic                     md_stall,
    output logic                     rf_wren,
    output logic [4:0]               rf_reg,
    output logic [31:0]              rf_data,
    input  logic [4:0]               query_a_reg,
    input  logic [4:0]               query_b_reg,
    output logic                     query_a_hit,
    output logic                     query_b_hit,
    output logic [$clog2(DEPTH):0]   pending_count
);

    logic        w_pw;
    logic [4:0]  w_md_reg;
    logic [31:0] w_md_data;
    logic        w_md_acc;
    logic        w_fifo_empty;
    logic        w_fifo_full;
    logic        w_head_valid;
    logic [4:0]  w_head_reg;
    logic [31:0] w_head_data;

    logic        w_sel_pop;
    logic        w_sel_bypass;
    logic        w_push;
    logic        w_push_valid;
    logic        w_wr_en;
    logic [4:0]  w_wr_reg;
    logic [31:0] w_wr_data;

    // Writes to r0 are architecturally void, so they never claim the port.
    assign w_pw = wb_wren && (wb_reg != REG_ZERO);

    assign w_md_reg  = md_exception ? EXC_REG  : md_reg;
    assign w_md_data = md_exception ? EXC_CODE : md_data;

    assign md_stall = w_fifo_full;
    assign w_md_acc = md_valid && !w_fifo_full;

    // Priority: pipeline, then FIFO head, then direct bypass of a fresh
    // mult/div result. Bypass is only legal with an empty FIFO so results
    // never overtake older parked ones.
    always_comb begin
        w_sel_pop    = 1'b0;
        w_sel_bypass = 1'b0;
        w_wr_en      = 1'b0;
        w_wr_reg     = wb_reg;
        w_wr_data    = wb_data;
        if (w_pw) begin
            w_wr_en = 1'b1;
        end else if (!w_fifo_empty) begin
            w_sel_pop = 1'b1;
            w_wr_en   = w_head_valid;
            w_wr_reg  = w_head_reg;
            w_wr_data = w_head_data;
        end else if (w_md_acc && (w_md_reg != REG_ZERO)) begin
            w_sel_bypass = 1'b1;
            w_wr_en      = 1'b1;
            w_wr_reg     = w_md_reg;
            w_wr_data    = w_md_data;
        end
    end

    // A mult/div result is always older than the instruction writing back
    // now, so a same-register pipeline write makes it stale on arrival.
    assign w_push       = w_md_acc && !w_sel_bypass;
    assign w_push_valid = (w_md_reg != REG_ZERO) && !(w_pw && (w_md_reg == wb_reg));

    wb_result_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock         (clock),
        .reset         (reset),
        .i_push        (w_push),
        .i_push_valid  (w_push_valid),
        .i_push_reg    (w_md_reg),
        .i_push_data   (w_md_data),
        .i_pop         (w_sel_pop),
        .i_squash_en   (w_pw),
        .i_squash_reg  (wb_reg),
        .i_query_a_reg (query_a_reg),
        .i_query_b_reg (query_b_reg),
        .o_query_a_hit (query_a_hit),
        .o_query_b_hit (query_b_hit),
        .o_head_valid  (w_head_valid),
        .o_head_reg    (w_head_reg),
        .o_head_data   (w_head_data),
        .o_count       (pending_count),
        .o_empty       (w_fifo_empty),
        .o_full        (w_fifo_full)
    );

    // rf_reg/rf_data keep their last written value on idle cycles.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rf_wren <= 1'b0;
            rf_reg  <= '0;
            rf_data <= '0;
        end else begin
            rf_wren <= w_wr_en;
            if (w_wr_en) begin
                rf_reg  <= w_wr_reg;
                rf_data <= w_wr_data;
            end
        end
    end

endmodule
